// File: rtl/scroll_msg_if.sv
// Write port, run/direction controls and display outputs of scroll_msg.
// The master side drives requests; the slave side is the message source.
interface scroll_msg_if #(
    parameter int N     = 7,
    parameter int DEPTH = 16
);
    localparam int AW = $clog2(DEPTH);

    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [4:0]    wr_char;
    logic          run;
    logic          cw;
    logic          scan_tick;
    logic          step;
    logic [AW-1:0] pos;
    logic [N-1:0]  in0, in1, in2, in3, in4, in5, in6, in7;

    modport master (
        output wr_valid, wr_addr, wr_char, run, cw,
        input  wr_ready, scan_tick, step, pos,
        input  in0, in1, in2, in3, in4, in5, in6, in7
    );

    modport slave (
        input  wr_valid, wr_addr, wr_char, run, cw,
        output wr_ready, scan_tick, step, pos,
        output in0, in1, in2, in3, in4, in5, in6, in7
    );
endinterface

// File: rtl/scroll_msg.sv
// Message buffer with a scrolling 8-digit window for the seven-segment path.
// Each window digit is encoded and registered by its own lane instance.
module scroll_msg_lane #(
    parameter int N = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [4:0]   i_code,
    output logic [N-1:0] o_seg
);
    // Active-low segments, bit0 = a ... bit6 = g
    function automatic logic [6:0] enc(input logic [4:0] c);
        case (c)
            5'd0:    enc = 7'h40;
            5'd1:    enc = 7'h79;
            5'd2:    enc = 7'h24;
            5'd3:    enc = 7'h30;
            5'd4:    enc = 7'h19;
            5'd5:    enc = 7'h12;
            5'd6:    enc = 7'h02;
            5'd7:    enc = 7'h78;
            5'd8:    enc = 7'h00;
            5'd9:    enc = 7'h10;
            5'd10:   enc = 7'h08;
            5'd11:   enc = 7'h03;
            5'd12:   enc = 7'h46;
            5'd13:   enc = 7'h21;
            5'd14:   enc = 7'h06;
            5'd15:   enc = 7'h0E;
            5'd17:   enc = 7'h3F;
            default: enc = 7'h7F;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) o_seg <= N'(7'h7F);
        else      o_seg <= N'(enc(i_code));
    end
endmodule

module scroll_msg #(
    parameter int N          = 7,
    parameter int DEPTH      = 16,
    parameter int SCROLL_DIV = 25_000_000,
    parameter int SCAN_DIV   = 100_000
) (
    input logic         clk,
    input logic         rst,
    scroll_msg_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(SCROLL_DIV);
    localparam int CW = $clog2(SCAN_DIV);
    localparam int NL = 8;
    localparam logic [SW-1:0] SC_MAX = SW'(SCROLL_DIV - 1);
    localparam logic [CW-1:0] SN_MAX = CW'(SCAN_DIV - 1);

    typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_DRAIN} state_t;

    state_t                  r_state, w_state_nxt;
    logic [DEPTH-1:0][4:0]   r_msg;
    logic [SW-1:0]           r_div, w_div_nxt;
    logic                    r_step;
    logic [AW-1:0]           r_pos;
    logic [CW-1:0]           r_scan, w_scan_nxt;
    logic                    r_tick;
    logic                    w_wr_ready, w_wr_fire;
    logic [NL-1:0][4:0]      w_code;
    logic [NL-1:0][N-1:0]    w_seg;

    assign w_wr_ready = (r_state == ST_STOP);
    assign w_wr_fire  = bus.wr_valid && w_wr_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_STOP;
        else      r_state <= w_state_nxt;
    end

    // DRAIN only parks once the window is home and no step is moving it away
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_STOP:  if (bus.run) w_state_nxt = ST_RUN;
            ST_RUN:   if (!bus.run) w_state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (bus.run)                          w_state_nxt = ST_RUN;
                else if (r_pos == '0 && !r_step)      w_state_nxt = ST_STOP;
            end
            default:  w_state_nxt = ST_STOP;
        endcase
    end

    // Divider holds at 0 while in STOP and is cleared on the way into STOP
    always_comb begin
        w_div_nxt = '0;
        if (r_state != ST_STOP && w_state_nxt != ST_STOP)
            w_div_nxt = (r_div == SC_MAX) ? '0 : r_div + SW'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div  <= '0;
            r_step <= 1'b0;
            r_pos  <= '0;
        end else begin
            r_div  <= w_div_nxt;
            r_step <= (w_div_nxt == SC_MAX);
            if (r_step) r_pos <= bus.cw ? r_pos + AW'(1) : r_pos - AW'(1);
        end
    end

    assign w_scan_nxt = (r_scan == SN_MAX) ? '0 : r_scan + CW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scan <= '0;
            r_tick <= 1'b0;
        end else begin
            r_scan <= w_scan_nxt;
            r_tick <= (w_scan_nxt == SN_MAX);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)           r_msg <= {DEPTH{5'd16}};
        else if (w_wr_fire) r_msg[bus.wr_addr] <= bus.wr_char;
    end

    for (genvar k = 0; k < NL; k++) begin : g_lane
        assign w_code[k] = r_msg[r_pos + AW'(k)];
        scroll_msg_lane #(.N(N)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .i_code (w_code[k]),
            .o_seg  (w_seg[k])
        );
    end

    assign bus.wr_ready  = w_wr_ready;
    assign bus.step      = r_step;
    assign bus.scan_tick = r_tick;
    assign bus.pos       = r_pos;
    assign bus.in0       = w_seg[0];
    assign bus.in1       = w_seg[1];
    assign bus.in2       = w_seg[2];
    assign bus.in3       = w_seg[3];
    assign bus.in4       = w_seg[4];
    assign bus.in5       = w_seg[5];
    assign bus.in6       = w_seg[6];
    assign bus.in7       = w_seg[7];
endmodule

// File: tb/tb_scroll_msg.sv
// Directed bench for scroll_msg: DEPTH 16, SCROLL_DIV 4, SCAN_DIV 3.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_scroll_msg;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vec  = 0;
    int   miss = 0;

    always #5 clk = ~clk;

    scroll_msg_if #(.N(7), .DEPTH(16)) bus ();

    scroll_msg #(.N(7), .DEPTH(16), .SCROLL_DIV(4), .SCAN_DIV(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [6:0] ins [8];
    assign ins[0] = bus.in0;
    assign ins[1] = bus.in1;
    assign ins[2] = bus.in2;
    assign ins[3] = bus.in3;
    assign ins[4] = bus.in4;
    assign ins[5] = bus.in5;
    assign ins[6] = bus.in6;
    assign ins[7] = bus.in7;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec++;
        assert (obs === exp) else begin
            miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_blank(input string tag);
        for (int k = 0; k < 8; k++) chk($sformatf("%s_in%0d", tag, k), 32'(ins[k]), 32'h7F);
    endtask

    logic [6:0] first8 [8];

    initial begin
        first8 = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_char  = '0;
        bus.run      = 1'b0;
        bus.cw       = 1'b1;

        // reset state
        cyc(2);
        chk_blank("rst");
        chk("rst_pos", 32'(bus.pos), 0);
        chk("rst_ready", 32'(bus.wr_ready), 1);
        chk("rst_step", 32'(bus.step), 0);
        chk("rst_tick", 32'(bus.scan_tick), 0);

        // scan tick: high after edges 2 and 5 following release
        rst = 1'b1;
        cyc(1); chk("tick_e1", 32'(bus.scan_tick), 0);
        cyc(1); chk("tick_e2", 32'(bus.scan_tick), 1);
        cyc(1); chk("tick_e3", 32'(bus.scan_tick), 0);
        cyc(1); chk("tick_e4", 32'(bus.scan_tick), 0);
        cyc(1); chk("tick_e5", 32'(bus.scan_tick), 1);
        chk("idle_step", 32'(bus.step), 0);

        // write codes 0..15
        for (int a = 0; a < 16; a++) begin
            bus.wr_valid = 1'b1;
            bus.wr_addr  = 4'(a);
            bus.wr_char  = 5'(a);
            cyc(1);
        end
        bus.wr_valid = 1'b0;
        cyc(1);
        for (int k = 0; k < 8; k++) chk($sformatf("wr_in%0d", k), 32'(ins[k]), 32'(first8[k]));

        // upward scroll with wrap
        bus.run = 1'b1;
        bus.cw  = 1'b1;
        cyc(3); chk("first_step_early", 32'(bus.step), 0);
        cyc(1); chk("first_step", 32'(bus.step), 1);
        chk("first_step_pos", 32'(bus.pos), 0);
        for (int p = 1; p <= 16; p++) begin
            cyc(1);
            chk($sformatf("up_pos%0d", p), 32'(bus.pos), 32'(p % 16));
            chk($sformatf("up_nostep%0d", p), 32'(bus.step), 0);
            cyc(1);
            if (p == 12) begin
                chk("p12_in4", 32'(bus.in4), 32'h40);
                chk("p12_in5", 32'(bus.in5), 32'h79);
                chk("p12_in6", 32'(bus.in6), 32'h24);
                chk("p12_in7", 32'(bus.in7), 32'h30);
                chk("p12_in0", 32'(bus.in0), 32'h46);
            end
            cyc(2);
            chk($sformatf("up_step%0d", p), 32'(bus.step), 1);
        end

        // downward from pos 0
        bus.cw = 1'b0;
        cyc(1); chk("down_pos15", 32'(bus.pos), 15);
        cyc(1); chk("down_in0", 32'(bus.in0), 32'h0E);
        chk("down_in1", 32'(bus.in1), 32'h40);
        cyc(2); chk("down_step", 32'(bus.step), 1);
        for (int p = 14; p >= 6; p--) begin
            cyc(1); chk($sformatf("down_pos%0d", p), 32'(bus.pos), 32'(p));
            cyc(3); chk($sformatf("down_step%0d", p), 32'(bus.step), 1);
        end
        cyc(1); chk("down_pos5", 32'(bus.pos), 5);

        // drain with a write held pending
        bus.run      = 1'b0;
        bus.wr_valid = 1'b1;
        bus.wr_addr  = 4'd0;
        bus.wr_char  = 5'd17;
        cyc(1); chk("drain_ready", 32'(bus.wr_ready), 0);
        cyc(3);
        for (int p = 4; p >= 0; p--) begin
            chk($sformatf("drain_pos%0d", p), 32'(bus.pos), 32'(p));
            chk($sformatf("drain_ready%0d", p), 32'(bus.wr_ready), 0);
            if (p > 0) cyc(4);
        end
        cyc(1); chk("stop_ready", 32'(bus.wr_ready), 1);
        chk("stop_in0_unwritten", 32'(bus.in0), 32'h40);
        cyc(1); bus.wr_valid = 1'b0;
        chk("stop_pos", 32'(bus.pos), 0);
        chk("stop_step", 32'(bus.step), 0);
        cyc(1); chk("dash_in0", 32'(bus.in0), 32'h3F);

        // reset mid-run at pos 9
        bus.run = 1'b1;
        bus.cw  = 1'b1;
        cyc(37); chk("mid_pos9", 32'(bus.pos), 9);
        cyc(1);  chk("mid_in0", 32'(bus.in0), 32'h10);
        chk("mid_ready", 32'(bus.wr_ready), 0);
        #2 rst = 1'b0;
        #1;
        chk("arst_pos", 32'(bus.pos), 0);
        chk("arst_step", 32'(bus.step), 0);
        chk("arst_tick", 32'(bus.scan_tick), 0);
        chk("arst_ready", 32'(bus.wr_ready), 1);
        chk_blank("arst");
        bus.run = 1'b0;
        cyc(2);
        rst = 1'b1;
        cyc(2);
        chk_blank("post_rst");
        chk("post_pos", 32'(bus.pos), 0);
        chk("post_ready", 32'(bus.wr_ready), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end
endmodule
